// File: rtl/fib_kbd_pkg.sv
// Shared scan-code constants, entry state encoding and digit decode helper
// for the Fibonacci calculator keyboard front end.
package fib_kbd_pkg;

  // Digit make-codes (PS/2 set 2, main row)
  localparam logic [7:0] KEY_0 = 8'h45;
  localparam logic [7:0] KEY_1 = 8'h16;
  localparam logic [7:0] KEY_2 = 8'h1E;
  localparam logic [7:0] KEY_3 = 8'h26;
  localparam logic [7:0] KEY_4 = 8'h25;
  localparam logic [7:0] KEY_5 = 8'h2E;
  localparam logic [7:0] KEY_6 = 8'h36;
  localparam logic [7:0] KEY_7 = 8'h3D;
  localparam logic [7:0] KEY_8 = 8'h3E;
  localparam logic [7:0] KEY_9 = 8'h46;

  // Control make-codes and prefixes
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BKSP  = 8'h66;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] ZERO_FILL = 8'h00;

  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,
    S_ONE   = 3'd1,
    S_TWO   = 3'd2,
    S_START = 3'd3,
    S_BUSY  = 3'd4
  } state_t;

  // True when the make-code is one of the ten decimal digit keys
  function automatic logic is_digit(input logic [7:0] code);
    case (code)
      KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
      KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: is_digit = 1'b1;
      default:                           is_digit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_make_filter.sv
// Strips break (F0) and extended (E0) prefixed bytes from the PS/2 byte
// stream. make_tick is combinational so the controller acts on the same
// rx_done_tick cycle; only the prefix flags are state.
module ps2_make_filter (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       make_tick,
  output logic [7:0] make_code
);
  import fib_kbd_pkg::*;

  logic brk;
  logic ext;
  logic is_prefix;

  assign is_prefix = (rx_data == KEY_BREAK) || (rx_data == KEY_EXT);
  assign make_tick = rx_done_tick && !is_prefix && !brk && !ext;
  assign make_code = rx_data;

  // Track pending prefixes; the first non-prefix byte after them is swallowed
  always_ff @(posedge clk) begin
    if (reset) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (rx_done_tick) begin
      if (rx_data == KEY_BREAK) begin
        brk <= 1'b1;
      end else if (rx_data == KEY_EXT) begin
        ext <= 1'b1;
      end else begin
        brk <= 1'b0;
        ext <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fib_key_entry_ctrl.sv
// Operand entry sequencer: collects up to two decimal digit make-codes,
// starts the Fibonacci unit on Enter and locks out keys until calc_done.
// Optional inter-key idle timeout is compiled in with FIB_KEY_TIMEOUT_EN.
module fib_key_entry_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       calc_done,
  output logic [7:0] key_code_1,
  output logic [7:0] key_code_2,
  output logic       calc_start,
  output logic       busy,
  output logic [1:0] digit_cnt,
  output logic       entry_err
);
  import fib_kbd_pkg::*;

  state_t     state;
  logic       make_tick;
  logic [7:0] make_code;
  logic       key_digit;
  logic       key_enter;
  logic       key_bksp;
  logic       key_esc;
  logic       timeout_hit;

  ps2_make_filter u_filter (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .make_tick    (make_tick),
    .make_code    (make_code)
  );

  assign key_digit = make_tick && is_digit(make_code);
  assign key_enter = make_tick && (make_code == KEY_ENTER);
  assign key_bksp  = make_tick && (make_code == KEY_BKSP);
  assign key_esc   = make_tick && (make_code == KEY_ESC);

`ifdef FIB_KEY_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] idle_cnt;
  logic             idle_active;
  logic             idle_reload;

  assign idle_active = (state == S_ONE) || (state == S_TWO);
  assign idle_reload = (key_digit && ((state == S_EMPTY) || (state == S_ONE)))
                    || (key_bksp && idle_active);
  // Expiry only counts when no recognised key claims this cycle
  assign timeout_hit = idle_active && (idle_cnt == {CNT_W{1'b0}})
                    && !key_digit && !key_enter && !key_bksp && !key_esc;

  // Idle counter: reload on accepted digit/Backspace, count down while partial
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= {CNT_W{1'b0}};
    end else if (idle_reload) begin
      idle_cnt <= CNT_W'(TIMEOUT_CYCLES - 32'd1);
    end else if (idle_active && (idle_cnt != {CNT_W{1'b0}})) begin
      idle_cnt <= idle_cnt - CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Entry state machine with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_EMPTY;
      key_code_1 <= ZERO_FILL;
      key_code_2 <= ZERO_FILL;
      calc_start <= 1'b0;
      busy       <= 1'b0;
      digit_cnt  <= 2'd0;
      entry_err  <= 1'b0;
    end else begin
      calc_start <= 1'b0;
      entry_err  <= 1'b0;
      case (state)
        S_EMPTY: begin
          if (key_digit) begin
            key_code_1 <= ZERO_FILL;
            key_code_2 <= make_code;
            digit_cnt  <= 2'd1;
            state      <= S_ONE;
          end else if (key_enter) begin
            entry_err <= 1'b1;
          end
        end
        S_ONE: begin
          if (key_digit) begin
            key_code_1 <= key_code_2;
            key_code_2 <= make_code;
            digit_cnt  <= 2'd2;
            state      <= S_TWO;
          end else if (key_enter) begin
            calc_start <= 1'b1;
            busy       <= 1'b1;
            state      <= S_START;
          end else if (key_bksp) begin
            key_code_2 <= ZERO_FILL;
            digit_cnt  <= 2'd0;
            state      <= S_EMPTY;
          end else if (key_esc || timeout_hit) begin
            key_code_1 <= ZERO_FILL;
            key_code_2 <= ZERO_FILL;
            digit_cnt  <= 2'd0;
            entry_err  <= timeout_hit;
            state      <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (key_digit) begin
            entry_err <= 1'b1;
          end else if (key_enter) begin
            calc_start <= 1'b1;
            busy       <= 1'b1;
            state      <= S_START;
          end else if (key_bksp) begin
            key_code_2 <= key_code_1;
            key_code_1 <= ZERO_FILL;
            digit_cnt  <= 2'd1;
            state      <= S_ONE;
          end else if (key_esc || timeout_hit) begin
            key_code_1 <= ZERO_FILL;
            key_code_2 <= ZERO_FILL;
            digit_cnt  <= 2'd0;
            entry_err  <= timeout_hit;
            state      <= S_EMPTY;
          end
        end
        S_START: begin
          busy  <= 1'b1;
          state <= S_BUSY;
        end
        S_BUSY: begin
          if (calc_done) begin
            busy      <= 1'b0;
            digit_cnt <= 2'd0;
            state     <= S_EMPTY;
          end
        end
        default: begin
          busy      <= 1'b0;
          digit_cnt <= 2'd0;
          state     <= S_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_key_entry_ctrl.sv
// Self-checking bench for fib_key_entry_ctrl: directed scenarios plus a
// randomized run compared against a digit-list reference model.
// Timeout scenario only when FIB_KEY_TIMEOUT_EN is defined.
module tb_fib_key_entry_ctrl;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       calc_done = 1'b0;
  logic [7:0] key_code_1;
  logic [7:0] key_code_2;
  logic       calc_start;
  logic       busy;
  logic [1:0] digit_cnt;
  logic       entry_err;

  int checks = 0;
  int failures = 0;

  // Reference model: held codes, count, lockout phases, prefix pending
  logic [7:0] m_k1, m_k2;
  int         m_cnt, m_idle;
  bit         m_pfx, m_startph, m_wait, m_start, m_err;

  fib_key_entry_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .calc_done    (calc_done),
    .key_code_1   (key_code_1),
    .key_code_2   (key_code_2),
    .calc_start   (calc_start),
    .busy         (busy),
    .digit_cnt    (digit_cnt),
    .entry_err    (entry_err)
  );

  always #5 clk = ~clk;

  function automatic int digit_val(input logic [7:0] c);
    case (c)
      8'h45: return 0;  8'h16: return 1;  8'h1E: return 2;  8'h26: return 3;
      8'h25: return 4;  8'h2E: return 5;  8'h36: return 6;  8'h3D: return 7;
      8'h3E: return 8;  8'h46: return 9;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_k1 = 8'h00; m_k2 = 8'h00; m_cnt = 0; m_idle = 0;
    m_pfx = 1'b0; m_startph = 1'b0; m_wait = 1'b0; m_start = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input bit tick, input logic [7:0] d, input bit done);
    bit ev;
    bit handled;
    ev = tick && (d != 8'hF0) && (d != 8'hE0) && !m_pfx;
    if (tick) m_pfx = (d == 8'hF0) || (d == 8'hE0);
    m_start = 1'b0;
    m_err = 1'b0;
    handled = 1'b0;
    if (m_startph) begin
      m_startph = 1'b0;
      m_wait = 1'b1;
    end else if (m_wait) begin
      if (done) begin m_wait = 1'b0; m_cnt = 0; end
    end else begin
      if (ev && digit_val(d) >= 0) begin
        handled = 1'b1;
        if (m_cnt == 0) begin m_k1 = 8'h00; m_k2 = d; m_cnt = 1; m_idle = T - 1; end
        else if (m_cnt == 1) begin m_k1 = m_k2; m_k2 = d; m_cnt = 2; m_idle = T - 1; end
        else begin m_err = 1'b1; if (m_idle > 0) m_idle--; end
      end else if (ev && d == 8'h5A) begin
        handled = 1'b1;
        if (m_cnt == 0) m_err = 1'b1;
        else begin m_startph = 1'b1; m_start = 1'b1; end
      end else if (ev && d == 8'h66) begin
        handled = 1'b1;
        if (m_cnt == 1) begin m_k2 = 8'h00; m_cnt = 0; end
        else if (m_cnt == 2) begin m_k2 = m_k1; m_k1 = 8'h00; m_cnt = 1; m_idle = T - 1; end
      end else if (ev && d == 8'h76) begin
        handled = 1'b1;
        if (m_cnt > 0) begin m_k1 = 8'h00; m_k2 = 8'h00; m_cnt = 0; end
      end
`ifdef FIB_KEY_TIMEOUT_EN
      if (!handled && m_cnt > 0) begin
        if (m_idle == 0) begin m_k1 = 8'h00; m_k2 = 8'h00; m_cnt = 0; m_err = 1'b1; end
        else m_idle--;
      end
`endif
    end
  endtask

  // One clock: drive at negedge, update model at the edge, settle 1 time unit
  task automatic cycle(input bit tick, input logic [7:0] d, input bit done);
    @(negedge clk);
    rx_done_tick = tick; rx_data = d; calc_done = done;
    @(posedge clk);
    model_step(tick, d, done);
    #1;
  endtask

  task automatic key(input logic [7:0] d);
    cycle(1'b1, d, 1'b0);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00; calc_done = 1'b0;
    repeat (n) @(posedge clk);
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(2);
    checks++; if (key_code_1 !== 8'h00) begin failures++; $display("FAIL reset_k1 got=%h exp=00", key_code_1); end
    checks++; if (key_code_2 !== 8'h00) begin failures++; $display("FAIL reset_k2 got=%h exp=00", key_code_2); end
    checks++; if (calc_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", calc_start); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (digit_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", digit_cnt); end
    checks++; if (entry_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", entry_err); end
    release_reset();
  endtask

  task automatic test_two_digit_entry();
    key(8'h1E); key(8'hF0); key(8'h1E); key(8'h36); key(8'hF0); key(8'h36); key(8'h5A);
    checks++; if (calc_start !== 1'b1) begin failures++; $display("FAIL two_start got=%b exp=1", calc_start); end
    checks++; if ({key_code_1, key_code_2} !== 16'h1E36) begin failures++; $display("FAIL two_codes got=%h%h exp=1e36", key_code_1, key_code_2); end
    checks++; if (entry_err !== 1'b0) begin failures++; $display("FAIL two_err got=%b exp=0", entry_err); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++; if ({calc_start, busy} !== 2'b01) begin failures++; $display("FAIL two_busy start/busy got=%b%b exp=01", calc_start, busy); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if ({busy, digit_cnt} !== 3'b000) begin failures++; $display("FAIL two_done busy/cnt got=%b/%0d exp=0/0", busy, digit_cnt); end
    checks++; if ({key_code_1, key_code_2} !== 16'h1E36) begin failures++; $display("FAIL two_retain got=%h%h exp=1e36", key_code_1, key_code_2); end
  endtask

  task automatic test_single_digit();
    key(8'h46); key(8'h5A);
    checks++; if ({key_code_1, key_code_2, calc_start} !== {16'h0046, 1'b1}) begin failures++; $display("FAIL single got=%h%h start=%b exp=0046 start=1", key_code_1, key_code_2, calc_start); end
    checks++; if (digit_cnt !== 2'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", digit_cnt); end
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_overflow_err();
    key(8'h16); key(8'h1E); key(8'h26);
    checks++; if ({entry_err, calc_start} !== 2'b10) begin failures++; $display("FAIL ovf_err err/start got=%b%b exp=10", entry_err, calc_start); end
    checks++; if ({key_code_1, key_code_2, digit_cnt} !== {16'h161E, 2'd2}) begin failures++; $display("FAIL ovf_codes got=%h%h cnt=%0d exp=161e cnt=2", key_code_1, key_code_2, digit_cnt); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++; if (entry_err !== 1'b0) begin failures++; $display("FAIL ovf_pulse got=%b exp=0", entry_err); end
    key(8'h76);
  endtask

  task automatic test_backspace();
    key(8'h16); key(8'h1E); key(8'h66);
    checks++; if ({key_code_1, key_code_2, digit_cnt} !== {16'h0016, 2'd1}) begin failures++; $display("FAIL bksp got=%h%h cnt=%0d exp=0016 cnt=1", key_code_1, key_code_2, digit_cnt); end
    key(8'h66);
    checks++; if ({key_code_2, digit_cnt} !== {8'h00, 2'd0}) begin failures++; $display("FAIL bksp2 got=%h cnt=%0d exp=00 cnt=0", key_code_2, digit_cnt); end
    key(8'h5A);
    checks++; if ({entry_err, calc_start} !== 2'b10) begin failures++; $display("FAIL enter_empty err/start got=%b%b exp=10", entry_err, calc_start); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++; if ({busy, entry_err} !== 2'b00) begin failures++; $display("FAIL enter_empty_after busy/err got=%b%b exp=00", busy, entry_err); end
  endtask

  task automatic test_busy_collision();
    key(8'h25); key(8'h5A); cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h26, 1'b1);
    checks++; if ({busy, digit_cnt, entry_err} !== 4'b0000) begin failures++; $display("FAIL coll busy/cnt/err got=%b/%0d/%b exp=0/0/0", busy, digit_cnt, entry_err); end
    checks++; if ({key_code_1, key_code_2} !== 16'h0025) begin failures++; $display("FAIL coll_codes got=%h%h exp=0025", key_code_1, key_code_2); end
    key(8'hE0); key(8'h16);
    checks++; if ({digit_cnt, key_code_2} !== {2'd0, 8'h25}) begin failures++; $display("FAIL ext_filter cnt=%0d k2=%h exp cnt=0 k2=25", digit_cnt, key_code_2); end
  endtask

  task automatic test_reset_mid();
    key(8'h16); key(8'h1E);
    apply_reset(1);
    checks++; if ({key_code_1, key_code_2, calc_start, busy, digit_cnt, entry_err} !== 21'd0) begin failures++; $display("FAIL rst_two got=%h%h %b%b %0d %b exp=all zero", key_code_1, key_code_2, calc_start, busy, digit_cnt, entry_err); end
    release_reset();
    key(8'h36); key(8'h5A); cycle(1'b0, 8'h00, 1'b0);
    apply_reset(1);
    release_reset();
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if ({busy, digit_cnt, calc_start} !== 4'b0000) begin failures++; $display("FAIL rst_busy busy/cnt/start got=%b/%0d/%b exp=0/0/0", busy, digit_cnt, calc_start); end
  endtask

`ifdef FIB_KEY_TIMEOUT_EN
  task automatic test_timeout();
    key(8'h16);
    repeat (T - 1) cycle(1'b0, 8'h00, 1'b0);
    checks++; if ({digit_cnt, entry_err} !== 3'b010) begin failures++; $display("FAIL tmo_early cnt/err got=%0d/%b exp=1/0", digit_cnt, entry_err); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++; if ({entry_err, key_code_1, key_code_2, digit_cnt} !== {1'b1, 18'd0}) begin failures++; $display("FAIL tmo err=%b codes=%h%h cnt=%0d exp err=1 0000 cnt=0", entry_err, key_code_1, key_code_2, digit_cnt); end
  endtask
`endif

  function automatic logic [7:0] pick(input int r);
    case (r)
      0: return 8'h45;  1: return 8'h16;  2: return 8'h1E;  3: return 8'h26;
      4: return 8'h25;  5: return 8'h2E;  6: return 8'h36;  7: return 8'h3D;
      8: return 8'h3E;  9: return 8'h46;  10: return 8'h5A; 11: return 8'h66;
      12: return 8'h76; 13: return 8'hF0; 14: return 8'hE0;
      default: return 8'($urandom_range(255));
    endcase
  endfunction

  task automatic test_random();
    bit tick, done;
    logic [7:0] d;
    for (int i = 0; i < 600; i++) begin
      tick = ($urandom_range(3) != 0);
      d = pick($urandom_range(17));
      done = m_wait ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      cycle(tick, d, done);
      checks++;
      if ({key_code_1, key_code_2, calc_start, busy, digit_cnt, entry_err} !==
          {m_k1, m_k2, m_start, (m_startph || m_wait), 2'(m_cnt), m_err}) begin
        failures++;
        $display("FAIL rand[%0d] got k=%h%h st=%b bz=%b cnt=%0d err=%b exp k=%h%h st=%b bz=%b cnt=%0d err=%b",
                 i, key_code_1, key_code_2, calc_start, busy, digit_cnt, entry_err,
                 m_k1, m_k2, m_start, (m_startph || m_wait), m_cnt, m_err);
      end
      checks++;
      if (calc_start && entry_err) begin failures++; $display("FAIL rand_excl[%0d] start and err both high", i); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_two_digit_entry();
    test_single_digit();
    test_overflow_err();
    test_backspace();
    test_busy_collision();
    test_reset_mid();
`ifdef FIB_KEY_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
